// File: rtl/retire_trace_buf_pkg.sv
// Shared types for the retire trace recorder: record kinds,
// FSM encoding and the packed trace record (TRACE_INST_EN adds inst).
package proc_trace_pkg;

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_REG  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_ST   = 3'd3;
  localparam logic [2:0] KIND_STU  = 3'd4;
  localparam logic [2:0] KIND_HALT = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } trcState_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] inum;
    logic [15:0] pc;
`ifdef TRACE_INST_EN
    logic [15:0] inst;
`endif
    logic [15:0] wdata;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic [2:0]  wreg;
  } traceRec_t;

  localparam int REC_W = $bits(traceRec_t);

  function automatic logic [2:0] classify(
    input logic halt,
    input logic regWrite,
    input logic memRead,
    input logic memWrite
  );
    logic [2:0] k;
    k = KIND_NOP;
    if (halt)                     k = KIND_HALT;
    else if (regWrite && memWrite) k = KIND_STU;
    else if (memWrite)            k = KIND_ST;
    else if (regWrite && memRead) k = KIND_LD;
    else if (regWrite)            k = KIND_REG;
    return k;
  endfunction

endpackage

// File: rtl/retire_trace_buf_if.sv
// Retire capture bus plus trace drain port; master = core/consumer,
// slave = recorder. Field names follow the commit stage signals.
interface retire_trace_buf_if #(
  parameter int CNT_W = 32
);
  logic             cap_en;
  logic [15:0]      pc;
  logic [15:0]      inst;
  logic             reg_write;
  logic [2:0]       write_reg;
  logic [15:0]      write_data;
  logic             mem_read;
  logic             mem_write;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_data;
  logic             halt;
  logic             trc_valid;
  logic             trc_ready;
  logic [2:0]       trc_kind;
  logic [15:0]      trc_inum;
  logic [15:0]      trc_pc;
  logic [15:0]      trc_inst;
  logic [15:0]      trc_wdata;
  logic [15:0]      trc_maddr;
  logic [15:0]      trc_mdata;
  logic [2:0]       trc_reg;
  logic [CNT_W-1:0] trc_cycle;
  logic             stall_req;
  logic             overflow;
  logic             done;

  modport master (
    output cap_en, pc, inst, reg_write, write_reg,
    output write_data, mem_read, mem_write,
    output mem_addr, mem_data, halt, trc_ready,
    input  trc_valid, trc_kind, trc_inum, trc_pc,
    input  trc_inst, trc_wdata, trc_maddr, trc_mdata,
    input  trc_reg, trc_cycle, stall_req, overflow, done
  );

  modport slave (
    input  cap_en, pc, inst, reg_write, write_reg,
    input  write_data, mem_read, mem_write,
    input  mem_addr, mem_data, halt, trc_ready,
    output trc_valid, trc_kind, trc_inum, trc_pc,
    output trc_inst, trc_wdata, trc_maddr, trc_mdata,
    output trc_reg, trc_cycle, stall_req, overflow, done
  );
endinterface

// File: rtl/retire_trace_buf_fifo.sv
// trace_fifo: sync-reset FIFO, push/pop/full/empty/count.
// Push into a full FIFO succeeds only when a pop happens the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdata  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wdata;
  end
endmodule

// File: rtl/retire_trace_buf.sv
// Retire trace recorder: classify, number, timestamp, buffer, drain.
// Ports: clk, rst (sync, active-high), bus (slave). Macro: TRACE_INST_EN.
module retire_trace_buf
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input logic                clk,
  input logic                rst,
  retire_trace_buf_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = REC_W + CNT_W;

  trcState_t        state;
  trcState_t        nextState;
  logic             accept;
  logic             isDone;
  logic [CNT_W-1:0] cycleCount;
  logic [15:0]      inum;
  logic             haltPend;
  logic [FW-1:0]    pendWord;
  logic             overflowQ;

  traceRec_t        capRec;
  traceRec_t        headRec;
  logic [FW-1:0]    capWord;
  logic [FW-1:0]    pushWord;
  logic [FW-1:0]    headWord;
  logic             take;
  logic             roomFree;
  logic             fifoPush;
  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CW-1:0]    fifoCount;

  always_comb begin
    capRec       = '0;
    capRec.kind  = classify(bus.halt, bus.reg_write,
                            bus.mem_read, bus.mem_write);
    capRec.inum  = inum;
    capRec.pc    = bus.pc;
`ifdef TRACE_INST_EN
    capRec.inst  = bus.inst;
`endif
    capRec.wdata = bus.write_data;
    capRec.maddr = bus.mem_addr;
    capRec.mdata = bus.mem_data;
    capRec.wreg  = bus.write_reg;
  end

`ifndef TRACE_INST_EN
  logic unusedInst;
  assign unusedInst = ^bus.inst;
`endif

  assign capWord  = {cycleCount, capRec};
  assign take     = accept && bus.cap_en;
  assign fifoPop  = bus.trc_valid && bus.trc_ready;
  assign roomFree = !fifoFull || fifoPop;
  // a held halt owns the push slot; new captures are off by then
  assign fifoPush = haltPend || take;
  assign pushWord = haltPend ? pendWord : capWord;

  trace_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) traceFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .wdata (pushWord),
    .rdata (headWord),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCount <= '0;
      inum       <= '0;
      haltPend   <= 1'b0;
      pendWord   <= '0;
      overflowQ  <= 1'b0;
    end else begin
      if (!isDone) cycleCount <= cycleCount + 1'b1;
      if (take)    inum <= inum + 1'b1;
      if (take && !roomFree) begin
        if (bus.halt) begin
          haltPend <= 1'b1;
          pendWord <= capWord;
        end else begin
          overflowQ <= 1'b1;
        end
      end else if (haltPend && roomFree) begin
        haltPend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      ST_RUN:   if (take && bus.halt) nextState = ST_DRAIN;
      ST_DRAIN: if (fifoEmpty && !haltPend) nextState = ST_DONE;
      ST_DONE:  nextState = ST_DONE;
      default:  nextState = ST_RUN;
    endcase
  end

  always_comb begin
    accept = (state == ST_RUN);
    isDone = (state == ST_DONE);
  end

  assign headRec       = bus.trc_valid ?
                         traceRec_t'(headWord[REC_W-1:0]) : '0;
  assign bus.trc_valid = !fifoEmpty;
  assign bus.trc_kind  = headRec.kind;
  assign bus.trc_inum  = headRec.inum;
  assign bus.trc_pc    = headRec.pc;
`ifdef TRACE_INST_EN
  assign bus.trc_inst  = headRec.inst;
`else
  assign bus.trc_inst  = '0;
`endif
  assign bus.trc_wdata = headRec.wdata;
  assign bus.trc_maddr = headRec.maddr;
  assign bus.trc_mdata = headRec.mdata;
  assign bus.trc_reg   = headRec.wreg;
  assign bus.trc_cycle = bus.trc_valid ?
                         headWord[FW-1:REC_W] : '0;
  assign bus.stall_req = (fifoCount >= CW'(DEPTH - 1));
  assign bus.overflow  = overflowQ;
  assign bus.done      = isDone;
endmodule
